// File: rtl/branch_predict_unit.sv
// branch_predict_unit: direct-mapped BTB with per-entry saturating counters,
// zero-latency fetch lookup, EX-side training, mispredict redirect and statistics.
module branch_predict_unit #(
   parameter int ENTRIES = 64,
   parameter int TAG_W   = 8,
   parameter int CNT_W   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_pc,
   output logic        pred_hit,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_is_jump,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_pred_taken,
   input  logic [31:0] upd_pred_target,
   input  logic        flush_all,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic [31:0] branch_cnt,
   output logic [31:0] mispred_cnt
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam logic [CNT_W-1:0] L_MAX = '1;
   localparam logic [CNT_W-1:0] L_WT  = {1'b1, {(CNT_W-1){1'b0}}};
   localparam logic [CNT_W-1:0] L_WNT = {1'b0, {(CNT_W-1){1'b1}}};

   logic [ENTRIES-1:0] r_valid;
   logic [ENTRIES-1:0] r_jump;
   logic [TAG_W-1:0]   r_tag    [ENTRIES];
   logic [31:0]        r_target [ENTRIES];
   logic [CNT_W-1:0]   r_cnt    [ENTRIES];
   logic [31:0]        r_branch_cnt;
   logic [31:0]        r_mispred_cnt;

   logic [IDX_W-1:0] w_lidx, w_uidx;
   logic [TAG_W-1:0] w_ltag, w_utag;
   logic             w_uhit;
   logic [CNT_W-1:0] w_ucnt, w_cnt_nxt;
   logic             w_unused_bits;

   assign w_lidx = if_pc[IDX_W+1:2];
   assign w_ltag = if_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign w_uidx = upd_pc[IDX_W+1:2];
   assign w_utag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign w_unused_bits = ^{if_pc, upd_pc};

   assign pred_hit    = r_valid[w_lidx] & (r_tag[w_lidx] == w_ltag);
   assign pred_taken  = pred_hit & (r_jump[w_lidx] | r_cnt[w_lidx][CNT_W-1]);
   assign pred_target = pred_taken ? r_target[w_lidx] : if_pc + 32'd4;

   assign mispredict  = upd_valid & ((upd_pred_taken != upd_taken) |
                                     (upd_taken & (upd_pred_target != upd_target)));
   assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;
   assign branch_cnt  = r_branch_cnt;
   assign mispred_cnt = r_mispred_cnt;

   assign w_uhit = r_valid[w_uidx] & (r_tag[w_uidx] == w_utag);
   assign w_ucnt = r_cnt[w_uidx];

   always_comb begin
      w_cnt_nxt = upd_is_jump ? L_MAX :
                  upd_taken   ? ((w_ucnt == L_MAX) ? L_MAX : w_ucnt + 1'b1) :
                                ((w_ucnt == '0) ? '0 : w_ucnt - 1'b1);
   end

   // flush wins over a same-edge update, so nothing is allocated that edge
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= '0;
         r_jump  <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_tag[i]    <= '0;
            r_target[i] <= '0;
            r_cnt[i]    <= L_WNT;
         end
      end else if (flush_all) begin
         r_valid <= '0;
      end else if (upd_valid) begin
         if (w_uhit) begin
            r_cnt[w_uidx] <= w_cnt_nxt;
            if (upd_taken | upd_is_jump) r_target[w_uidx] <= upd_target;
         end else if (upd_taken) begin
            r_valid[w_uidx]  <= 1'b1;
            r_jump[w_uidx]   <= upd_is_jump;
            r_tag[w_uidx]    <= w_utag;
            r_target[w_uidx] <= upd_target;
            r_cnt[w_uidx]    <= upd_is_jump ? L_MAX : L_WT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_branch_cnt  <= '0;
         r_mispred_cnt <= '0;
      end else begin
         if (upd_valid & ~&r_branch_cnt) r_branch_cnt <= r_branch_cnt + 32'd1;
         if (mispredict & ~&r_mispred_cnt) r_mispred_cnt <= r_mispred_cnt + 32'd1;
      end
   end
endmodule
